// File: rtl/cve2_obi_arbiter.sv
// cve2_obi_arbiter: merges the instruction and data OBI ports onto one shared
// memory port. Responses are steered back through an in-order owner-ID FIFO.
// Build option: define CVE2_ARB_ROUND_ROBIN_EN for round-robin arbitration on
// simultaneous requests; otherwise the data port has fixed priority.
module cve2_obi_arbiter #(
   parameter int unsigned MaxOutstanding = 2
) (
   input  logic        clk_i,
   input  logic        rst_ni,

   input  logic        instr_req_i,
   input  logic [31:0] instr_addr_i,
   output logic        instr_gnt_o,
   output logic        instr_rvalid_o,
   output logic [31:0] instr_rdata_o,
   output logic        instr_err_o,

   input  logic        data_req_i,
   input  logic        data_we_i,
   input  logic [3:0]  data_be_i,
   input  logic [31:0] data_addr_i,
   input  logic [31:0] data_wdata_i,
   output logic        data_gnt_o,
   output logic        data_rvalid_o,
   output logic [31:0] data_rdata_o,
   output logic        data_err_o,

   output logic        bus_req_o,
   output logic        bus_we_o,
   output logic [3:0]  bus_be_o,
   output logic [31:0] bus_addr_o,
   output logic [31:0] bus_wdata_o,
   input  logic        bus_gnt_i,
   input  logic        bus_rvalid_i,
   input  logic [31:0] bus_rdata_i,
   input  logic        bus_err_i,

   output logic        busy_o
);

   localparam logic [2:0] MaxCnt = 3'(MaxOutstanding);

   logic [2:0]                cnt_q, cnt_d, wr_idx;
   logic [MaxOutstanding-1:0] ids_q, ids_d;
   logic                      locked_q, sel_q;
   logic                      sel_data, data_wins, req_sel;
   logic                      full, nonempty, push, pop, head_data;

`ifdef CVE2_ARB_ROUND_ROBIN_EN
   logic last_data_q;

   assign data_wins = ~last_data_q;

   // Remember which port won the most recent handshake; reset means "instruction last".
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)   last_data_q <= 1'b0;
      else if (push) last_data_q <= sel_data;
   end
`else
   assign data_wins = 1'b1;
`endif

   // Port select: a stalled request keeps its owner, otherwise arbitrate.
   always_comb begin
      sel_data = 1'b0;
      if (locked_q)                       sel_data = sel_q;
      else if (data_req_i && instr_req_i) sel_data = data_wins;
      else                                sel_data = data_req_i;
   end

   assign full      = (cnt_q == MaxCnt);
   assign nonempty  = (cnt_q != 3'd0);
   assign req_sel   = sel_data ? data_req_i : instr_req_i;
   // rst_ni gates the request so every output is quiet while reset is held.
   assign bus_req_o = rst_ni & ~full & req_sel;
   assign push      = bus_req_o & bus_gnt_i;
   assign pop       = bus_rvalid_i & nonempty;

   assign instr_gnt_o = push & ~sel_data;
   assign data_gnt_o  = push & sel_data;

   // Drive the selected payload; everything is zero when nothing is requested.
   always_comb begin
      bus_we_o    = 1'b0;
      bus_be_o    = 4'b0000;
      bus_addr_o  = 32'h0;
      bus_wdata_o = 32'h0;
      if (bus_req_o) begin
         if (sel_data) begin
            bus_we_o    = data_we_i;
            bus_be_o    = data_be_i;
            bus_addr_o  = data_addr_i;
            bus_wdata_o = data_wdata_i;
         end else begin
            bus_be_o    = 4'b1111;
            bus_addr_o  = instr_addr_i;
         end
      end
   end

   // Owner-ID shift FIFO: head at bit 0, new entries land just past the survivors.
   always_comb begin
      ids_d  = pop ? (ids_q >> 1) : ids_q;
      wr_idx = cnt_q - {2'b00, pop};
      for (int i = 0; i < int'(MaxOutstanding); i++) begin
         if (push && (wr_idx == 3'(i))) ids_d[i] = sel_data;
      end
      cnt_d = cnt_q + {2'b00, push} - {2'b00, pop};
   end

   // FIFO, count and request lock registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q    <= 3'd0;
         ids_q    <= '0;
         locked_q <= 1'b0;
         sel_q    <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         ids_q    <= ids_d;
         locked_q <= bus_req_o & ~bus_gnt_i;
         sel_q    <= sel_data;
      end
   end

   assign head_data = ids_q[0];

   // Steer the response to the FIFO head owner; a response with nothing outstanding goes nowhere.
   always_comb begin
      instr_rvalid_o = 1'b0;
      instr_rdata_o  = 32'h0;
      instr_err_o    = 1'b0;
      data_rvalid_o  = 1'b0;
      data_rdata_o   = 32'h0;
      data_err_o     = 1'b0;
      if (nonempty) begin
         if (head_data) begin
            data_rvalid_o  = bus_rvalid_i;
            data_rdata_o   = bus_rdata_i;
            data_err_o     = bus_err_i;
         end else begin
            instr_rvalid_o = bus_rvalid_i;
            instr_rdata_o  = bus_rdata_i;
            instr_err_o    = bus_err_i;
         end
      end
   end

   assign busy_o = nonempty;

   // A response with no outstanding transaction is a bus protocol violation.
   illegal_rsp_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
                                   !(bus_rvalid_i && !nonempty))
      else $warning("cve2_obi_arbiter: response with nothing outstanding was dropped");

endmodule

// File: tb/tb_cve2_obi_arbiter.sv
// Self-checking bench for cve2_obi_arbiter (MaxOutstanding = 2).
module tb_cve2_obi_arbiter;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        instr_req_i;
   logic [31:0] instr_addr_i;
   logic        instr_gnt_o, instr_rvalid_o, instr_err_o;
   logic [31:0] instr_rdata_o;
   logic        data_req_i, data_we_i;
   logic [3:0]  data_be_i;
   logic [31:0] data_addr_i, data_wdata_i;
   logic        data_gnt_o, data_rvalid_o, data_err_o;
   logic [31:0] data_rdata_o;
   logic        bus_req_o, bus_we_o;
   logic [3:0]  bus_be_o;
   logic [31:0] bus_addr_o, bus_wdata_o;
   logic        bus_gnt_i, bus_rvalid_i, bus_err_i;
   logic [31:0] bus_rdata_i;
   logic        busy_o;

   int n_chk = 0;
   int n_err = 0;
   bit exp_q[$];  // owner of each outstanding transaction, 1 = data

   cve2_obi_arbiter #(.MaxOutstanding(2)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i),
      .instr_gnt_o(instr_gnt_o), .instr_rvalid_o(instr_rvalid_o),
      .instr_rdata_o(instr_rdata_o), .instr_err_o(instr_err_o),
      .data_req_i(data_req_i), .data_we_i(data_we_i), .data_be_i(data_be_i),
      .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i),
      .data_gnt_o(data_gnt_o), .data_rvalid_o(data_rvalid_o),
      .data_rdata_o(data_rdata_o), .data_err_o(data_err_o),
      .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_be_o(bus_be_o),
      .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o),
      .bus_gnt_i(bus_gnt_i), .bus_rvalid_i(bus_rvalid_i),
      .bus_rdata_i(bus_rdata_i), .bus_err_i(bus_err_i),
      .busy_o(busy_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic nxt();
      @(posedge clk_i);
      #1;
   endtask

   // Called at a sampling point while bus_rvalid_i is driven with rd/er.
   task automatic chk_rsp(input string tag, input logic [31:0] rd, input logic er);
      bit id;
      if (exp_q.size() == 0) begin
         chk({tag, " stray instr_rvalid"}, instr_rvalid_o, 1'b0);
         chk({tag, " stray data_rvalid"}, data_rvalid_o, 1'b0);
      end else begin
         id = exp_q.pop_front();
         if (id) begin
            chk({tag, " data_rvalid"}, data_rvalid_o, 1'b1);
            chk({tag, " data_rdata"}, data_rdata_o, rd);
            chk({tag, " data_err"}, data_err_o, er);
            chk({tag, " instr_rvalid"}, instr_rvalid_o, 1'b0);
         end else begin
            chk({tag, " instr_rvalid"}, instr_rvalid_o, 1'b1);
            chk({tag, " instr_rdata"}, instr_rdata_o, rd);
            chk({tag, " instr_err"}, instr_err_o, er);
            chk({tag, " data_rvalid"}, data_rvalid_o, 1'b0);
         end
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      bit w;
      rst_ni       = 1'b0;
      instr_req_i  = 1'b1;
      instr_addr_i = 32'h100;
      data_req_i   = 1'b1;
      data_we_i    = 1'b1;
      data_be_i    = 4'b0011;
      data_addr_i  = 32'h2000;
      data_wdata_i = 32'h55;
      bus_gnt_i    = 1'b1;
      bus_rvalid_i = 1'b1;
      bus_rdata_i  = 32'h1234;
      bus_err_i    = 1'b0;

      // Reset holds every output at zero even with requests and a response pending.
      @(negedge clk_i);
      chk("rst bus_req", bus_req_o, 1'b0);
      chk("rst instr_gnt", instr_gnt_o, 1'b0);
      chk("rst data_gnt", data_gnt_o, 1'b0);
      chk("rst bus_addr", bus_addr_o, 32'h0);
      chk("rst busy", busy_o, 1'b0);
      chk("rst instr_rvalid", instr_rvalid_o, 1'b0);
      chk("rst data_rvalid", data_rvalid_o, 1'b0);
      nxt();
      bus_rvalid_i = 1'b0;
      rst_ni = 1'b1;

      // Simultaneous requests: data first, instruction after data drops.
      @(negedge clk_i);
      chk("tie bus_addr", bus_addr_o, 32'h2000);
      chk("tie data_gnt", data_gnt_o, 1'b1);
      chk("tie instr_gnt", instr_gnt_o, 1'b0);
      chk("tie bus_we", bus_we_o, 1'b1);
      chk("tie bus_be", bus_be_o, 4'b0011);
      chk("tie bus_wdata", bus_wdata_o, 32'h55);
      exp_q.push_back(1'b1);
      nxt();
      data_req_i = 1'b0;
      @(negedge clk_i);
      chk("instr bus_addr", bus_addr_o, 32'h100);
      chk("instr gnt", instr_gnt_o, 1'b1);
      chk("instr data_gnt", data_gnt_o, 1'b0);
      chk("instr bus_we", bus_we_o, 1'b0);
      chk("instr bus_be", bus_be_o, 4'b1111);
      chk("instr bus_wdata", bus_wdata_o, 32'h0);
      exp_q.push_back(1'b0);
      nxt();

      // FIFO full: third request blocked.
      instr_req_i = 1'b0;
      data_req_i  = 1'b1;
      data_addr_i = 32'h2004;
      @(negedge clk_i);
      chk("full bus_req", bus_req_o, 1'b0);
      chk("full data_gnt", data_gnt_o, 1'b0);
      chk("full busy", busy_o, 1'b1);
      nxt();

      // Full plus response: still no grant this cycle, grant next cycle.
      bus_rvalid_i = 1'b1;
      bus_rdata_i  = 32'h11111111;
      @(negedge clk_i);
      chk("full+rsp bus_req", bus_req_o, 1'b0);
      chk("full+rsp data_gnt", data_gnt_o, 1'b0);
      chk_rsp("full+rsp", 32'h11111111, 1'b0);
      nxt();
      bus_rvalid_i = 1'b0;
      @(negedge clk_i);
      chk("after pop data_gnt", data_gnt_o, 1'b1);
      chk("after pop bus_addr", bus_addr_o, 32'h2004);
      exp_q.push_back(1'b1);
      nxt();
      data_req_i = 1'b0;

      bus_rvalid_i = 1'b1;
      bus_rdata_i  = 32'hDEADBEEF;
      @(negedge clk_i);
      chk_rsp("rsp1", 32'hDEADBEEF, 1'b0);
      nxt();
      bus_rdata_i = 32'hCAFE0001;
      bus_err_i   = 1'b1;
      @(negedge clk_i);
      chk_rsp("rsp2", 32'hCAFE0001, 1'b1);
      nxt();
      bus_rvalid_i = 1'b0;
      bus_err_i    = 1'b0;
      @(negedge clk_i);
      chk("drained busy", busy_o, 1'b0);
      nxt();

      // Stalled instruction request keeps the bus while data starts requesting.
      bus_gnt_i    = 1'b0;
      instr_req_i  = 1'b1;
      instr_addr_i = 32'h300;
      data_we_i    = 1'b0;
      for (int c = 0; c < 3; c++) begin
         if (c == 1) begin
            data_req_i  = 1'b1;
            data_addr_i = 32'h4000;
         end
         @(negedge clk_i);
         chk($sformatf("lock%0d bus_req", c), bus_req_o, 1'b1);
         chk($sformatf("lock%0d bus_addr", c), bus_addr_o, 32'h300);
         chk($sformatf("lock%0d data_gnt", c), data_gnt_o, 1'b0);
         chk($sformatf("lock%0d instr_gnt", c), instr_gnt_o, 1'b0);
         nxt();
      end
      bus_gnt_i = 1'b1;
      @(negedge clk_i);
      chk("lock gnt instr_gnt", instr_gnt_o, 1'b1);
      chk("lock gnt data_gnt", data_gnt_o, 1'b0);
      chk("lock gnt bus_addr", bus_addr_o, 32'h300);
      exp_q.push_back(1'b0);
      nxt();
      instr_req_i = 1'b0;
      @(negedge clk_i);
      chk("post lock data_gnt", data_gnt_o, 1'b1);
      chk("post lock bus_addr", bus_addr_o, 32'h4000);
      exp_q.push_back(1'b1);
      nxt();
      data_req_i  = 1'b0;
      instr_req_i = 1'b1;
      instr_addr_i = 32'h304;
      @(negedge clk_i);
      chk("full2 bus_req", bus_req_o, 1'b0);
      chk("full2 instr_gnt", instr_gnt_o, 1'b0);
      nxt();
      bus_rvalid_i = 1'b1;
      bus_rdata_i  = 32'hDEADBEEF;
      @(negedge clk_i);
      chk("full2+rsp instr_gnt", instr_gnt_o, 1'b0);
      chk_rsp("instr first", 32'hDEADBEEF, 1'b0);
      nxt();
      bus_rvalid_i = 1'b0;
      @(negedge clk_i);
      chk("refill instr_gnt", instr_gnt_o, 1'b1);
      exp_q.push_back(1'b0);
      nxt();
      instr_req_i = 1'b0;
      @(negedge clk_i);
      chk("pre-rst busy", busy_o, 1'b1);

      // Reset with two outstanding discards them.
      rst_ni = 1'b0;
      #1;
      chk("mid-rst busy", busy_o, 1'b0);
      exp_q.delete();
      nxt();
      rst_ni = 1'b1;
      bus_rvalid_i = 1'b1;
      bus_rdata_i  = 32'hBAD0BAD0;
      @(negedge clk_i);
      chk_rsp("post-rst", 32'hBAD0BAD0, 1'b0);
      chk("post-rst busy", busy_o, 1'b0);
      nxt();
      bus_rvalid_i = 1'b0;

      // Continuous contention with a response every cycle.
      instr_req_i  = 1'b1;
      instr_addr_i = 32'h500;
      data_req_i   = 1'b1;
      data_addr_i  = 32'h6000;
      for (int k = 0; k < 6; k++) begin
`ifdef CVE2_ARB_ROUND_ROBIN_EN
         w = (k % 2 == 0);
`else
         w = 1'b1;
`endif
         bus_rvalid_i = (k > 0);
         bus_rdata_i  = 32'(k) + 32'hA0;
         @(negedge clk_i);
         chk($sformatf("cont%0d data_gnt", k), data_gnt_o, w);
         chk($sformatf("cont%0d instr_gnt", k), instr_gnt_o, !w);
         chk($sformatf("cont%0d bus_addr", k), bus_addr_o, w ? 32'h6000 : 32'h500);
         if (k > 0) chk_rsp($sformatf("cont%0d", k), 32'(k) + 32'hA0, 1'b0);
         exp_q.push_back(w);
         nxt();
      end
      instr_req_i = 1'b0;
      data_req_i  = 1'b0;
      for (int d = 0; d < 4 && exp_q.size() > 0; d++) begin
         bus_rvalid_i = 1'b1;
         bus_rdata_i  = 32'hF00 + 32'(d);
         @(negedge clk_i);
         chk_rsp($sformatf("drain%0d", d), 32'hF00 + 32'(d), 1'b0);
         nxt();
      end
      bus_rvalid_i = 1'b0;
      @(negedge clk_i);
      chk("final busy", busy_o, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
